// File: rtl/t07_fpu_pkg.sv
// Shared definitions for the team-07 FPU divider back end: FSM states and
// the IEEE-754 single-precision constants used by normalize/round/pack.
package t07_fpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam int          FP_BIAS    = 127;
    localparam int          FP_EXP_MAX = 255;

endpackage

// File: rtl/t07_fpu_round_pack.sv
// Combinational round-to-nearest-even and pack of a normalized quotient.
// Expects the leading one at mant[30]; bits 29:7 form the stored fraction.
module t07_fpu_round_pack
    import t07_fpu_pkg::*;
(
    input  logic              sgn,
    input  logic signed [9:0] exp,
    input  logic [31:0]       mant,
    input  logic              stk,
    output logic [31:0]       result,
    output logic              flag_ovf,
    output logic              flag_unf,
    output logic              flag_inexact
);

    localparam logic signed [9:0] EXP_TOP = 10'(FP_EXP_MAX);

    logic [22:0]       frac;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [23:0]       frac_sum;
    logic signed [9:0] exp_r;
    logic              unused_mant;

    // The integer bits are known (0 and 1) once normalized, so they carry no information here.
    assign unused_mant = ^mant[31:30];

    // Round the fraction, fold a significand carry into the exponent, then clamp to the exponent range.
    always_comb begin
        frac         = mant[29:7];
        guard        = mant[6];
        sticky       = (|mant[5:0]) | stk;
        inc          = guard & (sticky | frac[0]);
        frac_sum     = {1'b0, frac} + {23'd0, inc};
        exp_r        = exp + {9'd0, frac_sum[23]};
        result       = {sgn, exp_r[7:0], frac_sum[22:0]};
        flag_ovf     = 1'b0;
        flag_unf     = 1'b0;
        if (exp_r >= EXP_TOP) begin
            result   = {sgn, 8'hFF, 23'd0};
            flag_ovf = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            result   = {sgn, 31'd0};
            flag_unf = 1'b1;
        end
        flag_inexact = guard | sticky | flag_ovf | flag_unf;
    end

endmodule

// File: rtl/t07_fpu_div_norm.sv
// Normalize/round/pack stage behind the team-07 divider. Normalizes the Q2.30
// quotient one bit per cycle, rounds to nearest-even and packs a single.
// Denormal results flush to zero; specials bypass the datapath entirely.
module t07_fpu_div_norm
    import t07_fpu_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       quotient,
    input  logic              sticky_in,
    input  logic signed [9:0] exp_in,
    input  logic              sign_in,
    input  logic              is_nan,
    input  logic              is_inf,
    input  logic              is_zero,
    output logic [31:0]       result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              flag_ovf,
    output logic              flag_unf,
    output logic              flag_inexact
);

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       mant;
    logic signed [9:0] exp;
    logic              sgn;
    logic              stk;
    logic              special;
    logic [31:0]       rp_result;
    logic              rp_ovf;
    logic              rp_unf;
    logic              rp_inexact;

    assign special   = is_nan | is_inf | is_zero | (quotient == 32'd0);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    t07_fpu_round_pack u_round_pack (
        .sgn          (sgn),
        .exp          (exp),
        .mant         (mant),
        .stk          (stk),
        .result       (rp_result),
        .flag_ovf     (rp_ovf),
        .flag_unf     (rp_unf),
        .flag_inexact (rp_inexact)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: specials jump straight to DONE, otherwise normalize until bit 30 leads.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = special ? DONE : NORM;
            NORM:    if (!mant[31] && mant[30]) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, one normalization step per cycle, and result/flag registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mant         <= 32'd0;
            exp          <= 10'sd0;
            sgn          <= 1'b0;
            stk          <= 1'b0;
            result       <= 32'd0;
            flag_ovf     <= 1'b0;
            flag_unf     <= 1'b0;
            flag_inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mant <= quotient;
                        exp  <= exp_in;
                        sgn  <= sign_in;
                        stk  <= sticky_in;
                        if (special) begin
                            if (is_nan) begin
                                result <= FP_QNAN;
                            end else if (is_inf) begin
                                result <= {sign_in, 8'hFF, 23'd0};
                            end else begin
                                result <= {sign_in, 31'd0};
                            end
                            flag_ovf     <= 1'b0;
                            flag_unf     <= 1'b0;
                            flag_inexact <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    if (mant[31]) begin
                        mant <= {1'b0, mant[31:1]};
                        stk  <= stk | mant[0];
                        exp  <= exp + 10'sd1;
                    end else if (!mant[30]) begin
                        mant <= {mant[30:0], 1'b0};
                        exp  <= exp - 10'sd1;
                    end
                end
                ROUND: begin
                    result       <= rp_result;
                    flag_ovf     <= rp_ovf;
                    flag_unf     <= rp_unf;
                    flag_inexact <= rp_inexact;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t07_fpu_div_norm.sv
// Directed testbench for t07_fpu_div_norm with hand-computed expected values.
module tb_t07_fpu_div_norm;

    logic              clk;
    logic              nrst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       quotient;
    logic              sticky_in;
    logic signed [9:0] exp_in;
    logic              sign_in;
    logic              is_nan;
    logic              is_inf;
    logic              is_zero;
    logic [31:0]       result;
    logic              out_valid;
    logic              out_ready;
    logic              flag_ovf;
    logic              flag_unf;
    logic              flag_inexact;

    int n_checks = 0;
    int n_fail   = 0;

    t07_fpu_div_norm dut (
        .clk          (clk),
        .nrst         (nrst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .quotient     (quotient),
        .sticky_in    (sticky_in),
        .exp_in       (exp_in),
        .sign_in      (sign_in),
        .is_nan       (is_nan),
        .is_inf       (is_inf),
        .is_zero      (is_zero),
        .result       (result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .flag_ovf     (flag_ovf),
        .flag_unf     (flag_unf),
        .flag_inexact (flag_inexact)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation and let the DUT accept it; returns #1 after the accepting edge.
    task automatic start_op(input logic [31:0] q, input logic st, input logic [9:0] e,
                            input logic s, input logic n, input logic i, input logic z);
        @(negedge clk);
        quotient  = q;
        sticky_in = st;
        exp_in    = e;
        sign_in   = s;
        is_nan    = n;
        is_inf    = i;
        is_zero   = z;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    // Latency counts the accepting edge as 1; bounded so a stuck DUT cannot hang the run.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Complete the output handshake (out_ready assumed high).
    task automatic handshake();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        quotient  = '0;
        sticky_in = 1'b0;
        exp_in    = '0;
        sign_in   = 1'b0;
        is_nan    = 1'b0;
        is_inf    = 1'b0;
        is_zero   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset out_valid: got %b expected 0", out_valid); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("[TB] FAIL reset result: got %h expected 00000000", result); end
        n_checks++; if ({flag_ovf, flag_unf, flag_inexact} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset flags: got %b expected 000", {flag_ovf, flag_unf, flag_inexact}); end
    endtask

    // Table of directed arithmetic cases: 6/3, 1/3, rounding carry, right shift, overflow, underflow, worst case.
    task automatic test_arith();
        logic [31:0] q_t   [7] = '{32'h40000000, 32'h2AAAAAAA, 32'h7FFFFFFF, 32'h80000000, 32'h40000000, 32'h40000000, 32'h00000001};
        logic        st_t  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [9:0]  e_t   [7] = '{10'd128, 10'd126, 10'd127, 10'd127, 10'd300, -10'sd5, 10'd200};
        logic        s_t   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] r_t   [7] = '{32'h40000000, 32'h3EAAAAAB, 32'h40000000, 32'h40000000, 32'h7F800000, 32'h80000000, 32'h55000000};
        logic [2:0]  f_t   [7] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b101, 3'b011, 3'b000};
        int          l_t   [7] = '{3, 4, 3, 4, 3, 3, 33};
        int          lat;
        for (int k = 0; k < 7; k++) begin
            start_op(q_t[k], st_t[k], e_t[k], s_t[k], 1'b0, 1'b0, 1'b0);
            wait_valid(lat);
            n_checks++; if (result !== r_t[k]) begin n_fail++; $display("[TB] FAIL arith%0d result: got %h expected %h", k, result, r_t[k]); end
            n_checks++; if ({flag_ovf, flag_unf, flag_inexact} !== f_t[k]) begin n_fail++; $display("[TB] FAIL arith%0d flags ovf/unf/inx: got %b expected %b", k, {flag_ovf, flag_unf, flag_inexact}, f_t[k]); end
            n_checks++; if (lat != l_t[k]) begin n_fail++; $display("[TB] FAIL arith%0d latency: got %0d expected %0d", k, lat, l_t[k]); end
            handshake();
        end
    endtask

    // NaN, signed infinity, zero flag, and a zero quotient all take one cycle with no flags.
    task automatic test_specials();
        logic        n_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic        i_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        z_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        s_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] q_t [4] = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h00000000};
        logic [31:0] r_t [4] = '{32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h80000000};
        int          lat;
        for (int k = 0; k < 4; k++) begin
            start_op(q_t[k], 1'b1, 10'd127, s_t[k], n_t[k], i_t[k], z_t[k]);
            wait_valid(lat);
            n_checks++; if (result !== r_t[k]) begin n_fail++; $display("[TB] FAIL special%0d result: got %h expected %h", k, result, r_t[k]); end
            n_checks++; if ({flag_ovf, flag_unf, flag_inexact} !== 3'b000) begin n_fail++; $display("[TB] FAIL special%0d flags: got %b expected 000", k, {flag_ovf, flag_unf, flag_inexact}); end
            n_checks++; if (lat != 1) begin n_fail++; $display("[TB] FAIL special%0d latency: got %0d expected 1", k, lat); end
            handshake();
        end
    endtask

    // Output held while out_ready is low; stage refuses new work meanwhile.
    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        start_op(32'h2AAAAAAA, 1'b1, 10'd126, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_valid(lat);
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (out_valid !== 1'b1 || result !== 32'h3EAAAAAB || flag_inexact !== 1'b1) begin
                n_fail++; $display("[TB] FAIL backpressure hold cycle %0d: got valid=%b result=%h inx=%b expected valid=1 result=3eaaaaab inx=1", c, out_valid, result, flag_inexact);
            end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL backpressure in_ready cycle %0d: got %b expected 0", c, in_ready); end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL backpressure release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
    endtask

    // in_valid during busy cycles is ignored; in_ready returns the cycle after the handshake.
    task automatic test_back_to_back();
        int lat;
        start_op(32'h2AAAAAAA, 1'b1, 10'd126, 1'b0, 1'b0, 1'b0, 1'b0);
        quotient = 32'h12345678;
        is_nan   = 1'b1;
        in_valid = 1'b1;
        wait_valid(lat);
        in_valid = 1'b0;
        n_checks++; if (result !== 32'h3EAAAAAB) begin n_fail++; $display("[TB] FAIL b2b ignored input result: got %h expected 3eaaaaab", result); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b in_ready in DONE: got %b expected 0", in_ready); end
        handshake();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b after handshake: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid); end
        start_op(32'h40000000, 1'b0, 10'd128, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_valid(lat);
        n_checks++; if (result !== 32'hC0000000 || lat != 3) begin n_fail++; $display("[TB] FAIL b2b second op: got %h lat %0d expected c0000000 lat 3", result, lat); end
        handshake();
    endtask

    // Reset during NORM clears everything at once; the next operation still works.
    task automatic test_reset_mid_norm();
        int lat;
        start_op(32'h00000001, 1'b0, 10'd200, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset handshake: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
        n_checks++; if (result !== 32'h0 || {flag_ovf, flag_unf, flag_inexact} !== 3'b000) begin n_fail++; $display("[TB] FAIL midreset outputs: got result=%h flags=%b expected 0/000", result, {flag_ovf, flag_unf, flag_inexact}); end
        @(negedge clk);
        nrst = 1'b1;
        start_op(32'h2AAAAAAA, 1'b1, 10'd126, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_valid(lat);
        n_checks++; if (result !== 32'h3EAAAAAB || flag_inexact !== 1'b1 || lat != 4) begin n_fail++; $display("[TB] FAIL midreset recovery: got %h inx=%b lat %0d expected 3eaaaaab inx=1 lat 4", result, flag_inexact, lat); end
        handshake();
    endtask

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_arith();
        test_specials();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_norm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
